// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU fetch path:
// opcodes, fetch-unit mode codes and the fetch sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OPC_JMP  = 4'b1100;
  localparam logic [3:0] OPC_JAL  = 4'b1101;
  localparam logic [3:0] OPC_JR   = 4'b1110;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [1:0] FC_NORMAL = 2'b00;
  localparam logic [1:0] FC_JUMP   = 2'b01;
  localparam logic [1:0] FC_RETURN = 2'b10;
  localparam logic [1:0] FC_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

endpackage

// File: rtl/adder_10bits.sv
// 10-bit ripple adder with carry in/out.
// Ports: a, b (addends), cin -> sum, cout.
module adder_10bits (
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic       cin,
  output logic [9:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {10'd0, cin};

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: FETCH -> DECODE -> EXEC, HALT on the halt opcode.
// Ports: clk, reset (sync, high); instr, imem_ready, stall, pcval in;
// fetch_control, ir, ir_valid, ra_we, ra_wdata, halted, retired out.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [3:0] OPC_JMP  = 4'b1100,
  parameter logic [3:0] OPC_JAL  = 4'b1101,
  parameter logic [3:0] OPC_JR   = 4'b1110,
  parameter logic [3:0] OPC_HALT = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  instr,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic [9:0]  pcval,
  output logic [1:0]  fetch_control,
  output logic [9:0]  ir,
  output logic        ir_valid,
  output logic        ra_we,
  output logic [9:0]  ra_wdata,
  output logic        halted,
  output logic [15:0] retired
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] opc;
  logic       capture;
  logic       carry_unused;

  assign opc     = ir[9:6];
  assign capture = (state == ST_FETCH) && imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ir_valid is set only on the FETCH->DECODE edge, so a
  // stalled DECODE never repeats the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= 10'h000;
      ir_valid <= 1'b0;
      retired  <= 16'h0000;
    end else begin
      ir_valid <= capture;
      if (capture) begin
        ir <= instr;
      end
      if (state == ST_EXEC) begin
        retired <= retired + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH:  if (imem_ready) state_nxt = ST_DECODE;
      ST_DECODE: if (!stall) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (opc == OPC_HALT) state_nxt = ST_HALT;
        else state_nxt = ST_FETCH;
      end
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    fetch_control = FC_HOLD;
    ra_we         = 1'b0;
    halted        = 1'b0;
    unique case (state)
      ST_EXEC: begin
        if (opc == OPC_JMP) begin
          fetch_control = FC_JUMP;
        end else if (opc == OPC_JAL) begin
          fetch_control = FC_JUMP;
          ra_we         = 1'b1;
        end else if (opc == OPC_JR) begin
          fetch_control = FC_RETURN;
        end else if (opc == OPC_HALT) begin
          fetch_control = FC_HOLD;
        end else begin
          fetch_control = FC_NORMAL;
        end
      end
      ST_HALT: halted = 1'b1;
      default: fetch_control = FC_HOLD;
    endcase
  end

  adder_10bits u_ra_add (
    .a    (pcval),
    .b    (10'd1),
    .cin  (1'b0),
    .sum  (ra_wdata),
    .cout (carry_unused)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: per-instruction expectations are
// queued by the stimulus and checked by an independent monitor.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  instr = 10'h000;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  pcval = 10'h000;
  logic [1:0]  fetch_control;
  logic [9:0]  ir;
  logic        ir_valid;
  logic        ra_we;
  logic [9:0]  ra_wdata;
  logic        halted;
  logic [15:0] retired;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .pcval         (pcval),
    .fetch_control (fetch_control),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ra_we         (ra_we),
    .ra_wdata      (ra_wdata),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ir;
    logic [1:0] fc;
    logic       we;
    logic [9:0] wd;
    int         w;
    int         s;
    bit         halt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one instruction, straight from the opcode table.
  function automatic exp_t model(logic [9:0] ins, logic [9:0] pc,
                                 int w, int s);
    exp_t e;
    logic [3:0] op;
    op = ins[9:6];
    e.ir = ins;
    e.w = w;
    e.s = s;
    e.wd = 10'((int'(pc) + 1) % 1024);
    e.we = 1'b0;
    e.halt = 1'b0;
    case (op)
      4'hC: e.fc = 2'b01;
      4'hD: begin e.fc = 2'b01; e.we = 1'b1; end
      4'hE: e.fc = 2'b10;
      4'hF: begin e.fc = 2'b11; e.halt = 1'b1; end
      default: e.fc = 2'b00;
    endcase
    return e;
  endfunction

  // Monitor
  bit         rst_seen = 1'b1;
  logic [15:0] prev_ret = 16'h0;
  logic [15:0] exp_ret = 16'h0;
  logic [1:0] prev_fc = 2'b11;
  logic       prev_we = 1'b0;
  logic [9:0] prev_wd = 10'h0;
  int         cyc = 0;
  int         vcnt = 0;
  bit         mdl_halt = 1'b0;
  exp_t       me;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_fc", 32'(fetch_control), 32'h3);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_ra_we", 32'(ra_we), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        mdl_halt = 1'b0;
        exp_ret = 16'h0;
        cyc = 1;
        vcnt = 0;
      end else begin
        cyc++;
        if (retired != prev_ret) begin
          if (q.size() == 0) begin
            chk("exec_expected", 32'h0, 32'h1);
          end else begin
            me = q.pop_front();
            exp_ret = exp_ret + 16'd1;
            chk("exec_fc", 32'(prev_fc), 32'(me.fc));
            chk("exec_ra_we", 32'(prev_we), 32'(me.we));
            chk("exec_ra_wdata", 32'(prev_wd), 32'(me.wd));
            chk("retired", 32'(retired), 32'(exp_ret));
            chk("period", 32'(cyc - 1), 32'(me.w + me.s + 3));
            chk("ir_valid_count", 32'(vcnt), 32'h1);
            if (me.halt) mdl_halt = 1'b1;
          end
          cyc = 1;
          vcnt = 0;
        end else begin
          chk("hold_fc", 32'(prev_fc), 32'h3);
          chk("idle_ra_we", 32'(prev_we), 32'h0);
        end
        chk("halted", 32'(halted), 32'(mdl_halt));
        if (ir_valid) begin
          vcnt++;
          if (q.size() == 0) begin
            chk("ir_valid_expected", 32'h0, 32'h1);
          end else begin
            chk("ir", 32'(ir), 32'(q[0].ir));
            chk("ir_valid_cycle", 32'(cyc), 32'(q[0].w + 2));
          end
        end
      end
      prev_ret = retired;
      prev_fc = fetch_control;
      prev_we = ra_we;
      prev_wd = ra_wdata;
      rst_seen = reset;
    end
  end

  // Stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    q.delete();
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic run_instr(logic [9:0] ins, logic [9:0] pc,
                           int w, int s, bit rst_exec);
    q.push_back(model(ins, pc, w, s));
    pcval = pc;
    repeat (w) begin
      imem_ready = 1'b0;
      instr = 10'($urandom);
      stall = 1'($urandom);
      step();
    end
    imem_ready = 1'b1;
    instr = ins;
    stall = 1'($urandom);
    step();
    repeat (s) begin
      imem_ready = 1'($urandom);
      instr = 10'($urandom);
      stall = 1'b1;
      step();
    end
    imem_ready = 1'($urandom);
    instr = 10'($urandom);
    stall = 1'b0;
    step();
    imem_ready = 1'($urandom);
    instr = 10'($urandom);
    stall = 1'($urandom);
    if (rst_exec) begin
      reset = 1'b1;
      q.delete();
      step();
      reset = 1'b0;
    end else begin
      step();
    end
  endtask

  task automatic halt_seq(logic [9:0] ins, int w, int s);
    run_instr(ins, 10'($urandom), w, s, 1'b0);
    repeat (6) begin
      imem_ready = 1'($urandom);
      instr = 10'($urandom);
      stall = 1'($urandom);
      step();
    end
    do_reset(2);
  endtask

  initial begin
    logic [9:0] ins;
    int r;
    do_reset(2);
    repeat (3) run_instr(10'h041, 10'($urandom), 0, 0, 1'b0);
    run_instr(10'h041, 10'h010, 2, 3, 1'b0);
    run_instr(10'h340, 10'h3FF, 0, 0, 1'b0);
    run_instr(10'h380, 10'h123, 1, 2, 1'b0);
    run_instr(10'h300, 10'h200, 2, 1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      ins = 10'($urandom);
      case (r)
        6: ins[9:6] = 4'hC;
        7: ins[9:6] = 4'hD;
        8: ins[9:6] = 4'hE;
        9: ins[9:6] = 4'hF;
        default: ins[9:6] = 4'($urandom_range(0, 11));
      endcase
      if (r == 9) halt_seq(ins, $urandom_range(0, 3), $urandom_range(0, 3));
      else run_instr(ins, 10'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b0);
    end
    run_instr(10'h041, 10'h055, 0, 1, 1'b0);
    run_instr(10'h340, 10'h3FF, 1, 1, 1'b1);
    run_instr(10'h041, 10'h001, 0, 0, 1'b0);
    halt_seq(10'h3C0, 0, 0);
    run_instr(10'h041, 10'h002, 1, 0, 1'b0);
    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
